// File: rtl/fsm_step_counter_if.sv
// ---------------------------------------------------------------------------
// fsm_step_counter_if
// ---------------------------------------------------------------------------
// Purpose:
//    Groups the operator-facing signals of the step counter into one bundle.
//    The controlling side (board glue, testbench) uses the master modport.
//    The counter itself uses the slave modport.
//
// Signal summary (direction seen from the counter / slave side):
//    step       in   1      debounced pushbutton level, asynchronous to the
//                           clock; each rising edge requests one operation
//    mode       in   2      00 hold, 01 +1, 10 +STEP, 11 -1
//    clear      in   1      synchronous clear to zero
//    load       in   1      synchronous parallel load
//    loadValue  in   WIDTH  value taken on load (clamped to MODULUS-1)
//    count      out  WIDTH  registered count value
//    wrap       out  1      one-cycle pulse, the last update wrapped/clamped
//    atZero     out  1      count == 0
//    atMax      out  1      count == MODULUS-1
// ---------------------------------------------------------------------------
interface fsm_step_counter_if #(
   parameter int WIDTH = 4
);

   logic             step;
   logic [1:0]       mode;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] loadValue;
   logic [WIDTH-1:0] count;
   logic             wrap;
   logic             atZero;
   logic             atMax;

   // The controller drives the request side and observes the count.
   modport master (
      output step,
      output mode,
      output clear,
      output load,
      output loadValue,
      input  count,
      input  wrap,
      input  atZero,
      input  atMax
   );

   // The counter consumes the requests and publishes its state.
   modport slave (
      input  step,
      input  mode,
      input  clear,
      input  load,
      input  loadValue,
      output count,
      output wrap,
      output atZero,
      output atMax
   );

endinterface

// File: rtl/fsm_step_counter.sv
// ---------------------------------------------------------------------------
// fsm_step_counter
// ---------------------------------------------------------------------------
// Purpose:
//    Parametrised modulo up/down step counter running on the system clock.
//    A debounced pushbutton level (step) is synchronised with two flops and
//    edge-detected with a third, so each press yields exactly one operation
//    regardless of how long the button is held. On that operation the
//    count holds, adds 1, adds STEP or subtracts 1 according to mode.
//    Results outside 0..MODULUS-1 either wrap (SATURATE=0) or clamp
//    (SATURATE=1); either event raises the one-cycle wrap flag.
//    Clear and load are synchronous and take priority over a pending step
//    pulse, which they consume rather than defer.
//
// Parameters:
//    WIDTH     counter width in bits
//    MODULUS   count range is 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//    STEP      increment used for mode 10, 1 <= STEP <= MODULUS-1
//    SATURATE  0 = modulo wrap at both ends, 1 = clamp at both ends
//
// Ports:
//    i_clk     in   1   system clock, rising edge
//    i_rst_n   in   1   asynchronous active-low reset
//    bus       slave modport of fsm_step_counter_if (see that file)
// ---------------------------------------------------------------------------
module fsm_step_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 10,
   parameter int STEP     = 2,
   parameter int SATURATE = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   fsm_step_counter_if.slave     bus
);

   // Operation select as seen on the mode lines.
   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_INC  = 2'b01,
      MODE_STEP = 2'b10,
      MODE_DEC  = 2'b11
   } mode_e;

   // Arithmetic is done one bit wider than the count so that count+STEP
   // can never overflow before it is compared against the modulus.
   localparam int               W_EXT    = WIDTH + 1;
   localparam logic [WIDTH:0]   MOD_EXT  = W_EXT'(MODULUS);
   localparam logic [WIDTH:0]   STEP_EXT = W_EXT'(STEP);
   localparam logic [WIDTH:0]   ONE_EXT  = W_EXT'(1);
   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
   localparam logic             SAT_ON   = (SATURATE != 0);

   // Synchroniser / edge-detector chain and the derived one-cycle pulse.
   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic             w_pulse;

   // Architectural state of the counter.
   logic [WIDTH-1:0] r_count;
   logic             r_wrap;

   // Next-state candidates computed combinationally.
   mode_e            w_mode;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_stepNext;
   logic             w_stepWrap;
   logic [WIDTH-1:0] w_loadNext;

   assign w_mode  = mode_e'(bus.mode);

   // A press is recognised when the synchronised level has just risen:
   // r_s2 is the first flop safe to use, r_s3 is its one-cycle-old copy.
   assign w_pulse = r_s2 & ~r_s3;

   // Synchroniser for the asynchronous pushbutton level. r_s1 may go
   // metastable; r_s2 gives it a full cycle to settle; r_s3 remembers the
   // previous settled level for rising-edge detection. Reset empties the
   // chain, which also discards any pulse that was in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= bus.step;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // Result of a step operation for the currently selected mode, together
   // with whether it had to wrap or clamp. For increments the widened sum
   // is compared against the modulus; anything at or above it is out of
   // range. In saturate mode an out-of-range sum always differs from the
   // clamped MODULUS-1, so the flag is raised for every such case,
   // including an increment while already at the top. A decrement can
   // only leave the range from zero.
   always_comb begin
      w_sum      = {1'b0, r_count};
      w_stepNext = r_count;
      w_stepWrap = 1'b0;
      unique case (w_mode)
         MODE_HOLD: begin
            w_stepNext = r_count;
            w_stepWrap = 1'b0;
         end
         MODE_INC, MODE_STEP: begin
            if (w_mode == MODE_INC) begin
               w_sum = {1'b0, r_count} + ONE_EXT;
            end else begin
               w_sum = {1'b0, r_count} + STEP_EXT;
            end
            if (w_sum >= MOD_EXT) begin
               w_stepWrap = 1'b1;
               if (SAT_ON) begin
                  w_stepNext = MAX_VAL;
               end else begin
                  w_stepNext = WIDTH'(w_sum - MOD_EXT);
               end
            end else begin
               w_stepNext = w_sum[WIDTH-1:0];
            end
         end
         MODE_DEC: begin
            if (r_count == '0) begin
               w_stepWrap = 1'b1;
               if (SAT_ON) begin
                  w_stepNext = '0;
               end else begin
                  w_stepNext = MAX_VAL;
               end
            end else begin
               w_stepNext = r_count - ONE_VAL;
            end
         end
         default: begin
            w_stepNext = r_count;
            w_stepWrap = 1'b0;
         end
      endcase
   end

   // A load value outside the count range is pinned to the top value so
   // the counter can never hold an illegal state. When MODULUS equals
   // 2**WIDTH this comparison is never true and the value passes through.
   always_comb begin
      w_loadNext = bus.loadValue;
      if ({1'b0, bus.loadValue} >= MOD_EXT) begin
         w_loadNext = MAX_VAL;
      end
   end

   // Counter register. Priority on each edge is clear, then load, then a
   // step pulse, otherwise hold. A clear or load that coincides with a
   // pulse simply wins; the pulse is not remembered, because the edge
   // detector has already moved on. The wrap flag is rewritten every
   // cycle, so it is high for exactly the cycle after a wrapping update.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else if (bus.clear) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else if (bus.load) begin
         r_count <= w_loadNext;
         r_wrap  <= 1'b0;
      end else if (w_pulse) begin
         r_count <= w_stepNext;
         r_wrap  <= w_stepWrap;
      end else begin
         r_wrap  <= 1'b0;
      end
   end

   // Status flags are decoded straight from the count register so they
   // track it with no extra latency and carry no state of their own.
   assign bus.count  = r_count;
   assign bus.wrap   = r_wrap;
   assign bus.atZero = (r_count == '0);
   assign bus.atMax  = (r_count == MAX_VAL);

endmodule

// File: tb/tb_fsm_step_counter.sv
// ---------------------------------------------------------------------------
// tb_fsm_step_counter
// ---------------------------------------------------------------------------
// Drives three counters in lock-step from the same stimulus:
//    u0: WIDTH=4, MODULUS=10,  STEP=2,  wrap
//    u1: WIDTH=4, MODULUS=10,  STEP=2,  saturate
//    u2: WIDTH=8, MODULUS=200, STEP=50, wrap
// A behavioural model keeps the expected count/wrap of each as plain
// integers and derives the results with ordinary arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fsm_step_counter;

   logic       clk;
   logic       rst_n;
   logic       step;
   logic [1:0] mode;
   logic       clear;
   logic       load;
   logic [3:0] lv4;
   logic [7:0] lv8;

   int nCompared = 0;
   int nMismatch = 0;

   int pMod[3]  = '{10, 10, 200};
   int pStep[3] = '{2, 2, 50};
   int pSat[3]  = '{0, 1, 0};

   int mCount[3];
   int mWrap[3];

   fsm_step_counter_if #(.WIDTH(4)) bus0 ();
   fsm_step_counter_if #(.WIDTH(4)) bus1 ();
   fsm_step_counter_if #(.WIDTH(8)) bus2 ();

   assign bus0.step = step;  assign bus0.mode = mode;
   assign bus0.clear = clear; assign bus0.load = load; assign bus0.loadValue = lv4;
   assign bus1.step = step;  assign bus1.mode = mode;
   assign bus1.clear = clear; assign bus1.load = load; assign bus1.loadValue = lv4;
   assign bus2.step = step;  assign bus2.mode = mode;
   assign bus2.clear = clear; assign bus2.load = load; assign bus2.loadValue = lv8;

   fsm_step_counter #(.WIDTH(4), .MODULUS(10), .STEP(2), .SATURATE(0)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
   fsm_step_counter #(.WIDTH(4), .MODULUS(10), .STEP(2), .SATURATE(1)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
   fsm_step_counter #(.WIDTH(8), .MODULUS(200), .STEP(50), .SATURATE(0)) u2 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

   // Free-running system clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so a broken design can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic void modelReset();
      for (int k = 0; k < 3; k++) begin
         mCount[k] = 0;
         mWrap[k]  = 0;
      end
   endfunction

   function automatic void modelIdle();
      for (int k = 0; k < 3; k++) mWrap[k] = 0;
   endfunction

   function automatic void modelStep(input logic [1:0] m);
      int delta;
      int raw;
      for (int k = 0; k < 3; k++) begin
         case (m)
            2'b01:   delta = 1;
            2'b10:   delta = pStep[k];
            2'b11:   delta = -1;
            default: delta = 0;
         endcase
         raw = mCount[k] + delta;
         if (raw >= pMod[k]) begin
            mCount[k] = (pSat[k] != 0) ? pMod[k] - 1 : raw - pMod[k];
            mWrap[k]  = 1;
         end else if (raw < 0) begin
            mCount[k] = (pSat[k] != 0) ? 0 : raw + pMod[k];
            mWrap[k]  = 1;
         end else begin
            mCount[k] = raw;
            mWrap[k]  = 0;
         end
      end
   endfunction

   function automatic void modelCtrl(input int ctrl, input logic [3:0] v4, input logic [7:0] v8);
      int v;
      for (int k = 0; k < 3; k++) begin
         v = (k == 2) ? int'(v8) : int'(v4);
         if ((ctrl & 2) != 0)      mCount[k] = 0;
         else if (v >= pMod[k])    mCount[k] = pMod[k] - 1;
         else                      mCount[k] = v;
         mWrap[k] = 0;
      end
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      assert (got === exp) else begin
         nMismatch++;
         $error("[TB] FAIL %s u%0d observed=%0h expected=%0h", tag, k, got, exp);
      end
   endtask

   task automatic checkOutput(input string where);
      logic [31:0] gC[3];
      logic [31:0] gW[3];
      logic [31:0] gZ[3];
      logic [31:0] gM[3];
      gC[0] = {28'd0, bus0.count}; gW[0] = {31'd0, bus0.wrap};
      gZ[0] = {31'd0, bus0.atZero}; gM[0] = {31'd0, bus0.atMax};
      gC[1] = {28'd0, bus1.count}; gW[1] = {31'd0, bus1.wrap};
      gZ[1] = {31'd0, bus1.atZero}; gM[1] = {31'd0, bus1.atMax};
      gC[2] = {24'd0, bus2.count}; gW[2] = {31'd0, bus2.wrap};
      gZ[2] = {31'd0, bus2.atZero}; gM[2] = {31'd0, bus2.atMax};
      for (int k = 0; k < 3; k++) begin
         chk({where, ".count"},  k, gC[k], mCount[k]);
         chk({where, ".wrap"},   k, gW[k], mWrap[k]);
         chk({where, ".atZero"}, k, gZ[k], (mCount[k] == 0) ? 1 : 0);
         chk({where, ".atMax"},  k, gM[k], (mCount[k] == pMod[k] - 1) ? 1 : 0);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   // One press held for 'hold' sampled edges. The count must change on the
   // third edge after the first high sample and at no other time. With a
   // nonzero ctrl (1 load, 2 clear, 3 both) the control is applied on that
   // same third edge and must swallow the pulse. Mode is scrambled right
   // after the update to show it only matters on the updating edge.
   task automatic applyStimulus(input logic [1:0] m, input int hold, input int ctrl,
                                input logic [3:0] v4, input logic [7:0] v8);
      int last;
      last = ((hold > 3) ? hold : 3) + 1;
      step = 1'b1;
      mode = m;
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         if (c == 3) begin
            if (ctrl == 0) modelStep(m);
            else           modelCtrl(ctrl, v4, v8);
         end else begin
            modelIdle();
         end
         checkOutput((c == 3) ? "update" : "noUpdate");
         if (c == 2 && ctrl != 0) begin
            clear = ((ctrl & 2) != 0);
            load  = ((ctrl & 1) != 0);
            lv4   = v4;
            lv8   = v8;
         end
         if (c == 3) begin
            clear = 1'b0;
            load  = 1'b0;
            mode  = 2'($urandom);
         end
         if (c == hold) step = 1'b0;
      end
   endtask

   task automatic doCtrl(input int ctrl, input logic [3:0] v4, input logic [7:0] v8);
      clear = ((ctrl & 2) != 0);
      load  = ((ctrl & 1) != 0);
      lv4   = v4;
      lv8   = v8;
      @(negedge clk);
      modelCtrl(ctrl, v4, v8);
      checkOutput("ctrl");
      clear = 1'b0;
      load  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         modelIdle();
         checkOutput("idle");
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int r;
      rst_n = 1'b0;
      step  = 1'b0;
      mode  = 2'b00;
      clear = 1'b0;
      load  = 1'b0;
      lv4   = '0;
      lv8   = '0;
      $display("[TB] start");

      #3;
      modelReset();
      checkOutput("reset");
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // Twelve +1 presses: default counter runs 1..9,0,1,2.
      for (int i = 0; i < 12; i++) applyStimulus(2'b01, 3, 0, 4'd0, 8'd0);

      // +STEP from 8 / 180, then -1, then a hold press.
      doCtrl(1, 4'd8, 8'd180);
      applyStimulus(2'b10, 3, 0, 4'd0, 8'd0);
      applyStimulus(2'b11, 3, 0, 4'd0, 8'd0);
      applyStimulus(2'b00, 3, 0, 4'd0, 8'd0);

      // Top and bottom boundaries.
      doCtrl(1, 4'd9, 8'd199);
      applyStimulus(2'b01, 3, 0, 4'd0, 8'd0);
      doCtrl(1, 4'd0, 8'd0);
      applyStimulus(2'b11, 3, 0, 4'd0, 8'd0);

      // Long hold gives one update; shortest legal presses back to back.
      applyStimulus(2'b01, 20, 0, 4'd0, 8'd0);
      applyStimulus(2'b01, 1, 0, 4'd0, 8'd0);
      applyStimulus(2'b01, 1, 0, 4'd0, 8'd0);

      // Controls coinciding with a pulse, clamped load, clear over load.
      applyStimulus(2'b01, 3, 1, 4'd7, 8'd7);
      doCtrl(1, 4'd15, 8'd250);
      doCtrl(3, 4'd5, 8'd77);
      applyStimulus(2'b01, 3, 2, 4'd0, 8'd0);

      // Asynchronous reset while a pulse is in flight, with step still high.
      doCtrl(1, 4'd5, 8'd77);
      step = 1'b1;
      mode = 2'b01;
      idle(2);
      #2 rst_n = 1'b0;
      #1 modelReset();
      checkOutput("asyncReset");
      @(negedge clk);
      checkOutput("inReset");
      rst_n = 1'b1;
      idle(2);
      @(negedge clk);
      modelStep(2'b01);
      checkOutput("pressAtRelease");
      step = 1'b0;
      idle(1);

      // Randomised mix of presses, coincident controls and plain controls.
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6)
            applyStimulus(2'($urandom), $urandom_range(1, 5), 0, 4'd0, 8'd0);
         else if (r < 8)
            applyStimulus(2'($urandom), $urandom_range(1, 5), $urandom_range(1, 3),
                          4'($urandom), 8'($urandom));
         else
            doCtrl($urandom_range(1, 3), 4'($urandom), 8'($urandom));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/fsm_step_counter.md
# fsm_step_counter

Parametrised modulo step counter: the next generation of the board-level up/down counter FSM. It runs on the system clock instead of using a pushbutton as a clock. A Step strobe is synchronised and edge-detected on chip. On each detected Step, the counter holds, adds 1, adds STEP or subtracts 1, depending on Mode. Width, modulus, step size and wrap/saturate behaviour are parameters. It also adds synchronous clear, parallel load and status flags. Count feeds the existing hex-display decoder, one digit per 4 bits.

## Interface
- WIDTH, 4: counter width in bits.
- MODULUS, 10: count range is 0..MODULUS-1. Legal range 2 <= MODULUS <= 2^WIDTH.
- STEP, 2: increment applied for Mode=10. Legal range 1 <= STEP <= MODULUS-1.
- SATURATE, 0: 0 = modulo wrap at both ends; 1 = clamp at 0 and MODULUS-1.

- Clock  in  1  single system clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- Step  in  1  asynchronous level (pushbutton, already debounced), active-high. Each rising edge requests one count operation.
- Mode  in  2  operation select {w1,w0}: 00 hold, 01 +1, 10 +STEP, 11 -1.
- Clear  in  1  synchronous clear to 0.
- Load  in  1  synchronous parallel load.
- LoadValue  in  WIDTH  value for Load.
- Count  out  WIDTH  current count, registered.
- Wrap  out  1  one-cycle pulse: the last update wrapped or clamped.
- AtZero  out  1  Count == 0, decoded from the register.
- AtMax  out  1  Count == MODULUS-1, decoded from the register.

## Operation
- Step path: three flops s1→s2→s3; the internal pulse is s2 & ~s3. Exactly one operation per Step rising edge, however long Step stays high. A release and re-press gives another operation.
- FSM state is Count itself plus the synchroniser flops. There are no other hidden states.
- Per-edge priority: Reset (async) > Clear > Load > step pulse > hold.
- Clear: Count←0, Wrap←0.
- Load: Count←LoadValue. If LoadValue ≥ MODULUS, Count←MODULUS-1. Wrap←0.
- Step pulse with Mode:
  - 00: Count unchanged, Wrap←0.
  - 01: next = Count+1.
  - 10: next = Count+STEP.
  - 11: next = Count-1.
- Arithmetic uses WIDTH+1 bits internally, so no intermediate overflow is possible.
- Wrap mode (SATURATE=0):
  - Count+k ≥ MODULUS gives Count+k-MODULUS.
  - Count-1 from 0 gives MODULUS-1.
  - Wrap←1 for either case.
- Saturate mode (SATURATE=1):
  - The upper result clamps to MODULUS-1 and the lower result clamps to 0.
  - Wrap←1 only if clamping changed the result. Incrementing when already at MODULUS-1 also sets Wrap.
- Wrap is 0 on every cycle with no wrap/clamp update.
- Mode is sampled only on the edge that applies the pulse. Mode changes between pulses have no effect.
- A Clear or Load on the same edge as a pulse consumes the pulse: the pulse is discarded, not deferred.
- Reset values: Count=0, Wrap=0, AtZero=1, AtMax=0, s1=s2=s3=0.

## Timing
- Step latency: Step is high at rising edge E1 (s1 captures it). The pulse is valid during the cycle after E2. Count and Wrap update at E3. Count is visible after E3.
- Step must be held high for ≥1 clock period to be seen, and low for ≥1 clock period between presses.
- Clear/Load: single-cycle latency. Count is updated after the edge on which the signal is sampled high.
- AtZero/AtMax are combinational from Count and have no added latency. Wrap is registered and aligned with its Count update.
- Reset assertion clears all flops immediately, independent of Clock.
- Reset deassertion is synchronised externally. A Step already high at deassertion is seen as a new press: s1 fills on the first edge, and Count updates on the third edge.
- Reset mid-operation (pulse in flight in s2/s3) discards the pulse.

## Test plan
- Default params: reset, then 12 Step presses with Mode=01 → Count 1..9,0,1,2. Wrap pulses exactly once, on the 9→0 update. AtZero high after reset and after the wrap.
- Mode=10 from Count=8 → 0 with Wrap=1. Then Mode=11 from 0 → 9 with Wrap=1. Then Mode=00 press → Count stays 9, Wrap=0.
- SATURATE=1, MODULUS=10: Mode=01 from 9 → stays 9, Wrap=1. Mode=11 from 0 → stays 0, Wrap=1. Mode=10 from 8 → 9, Wrap=1.
- Step held high for 20 cycles → exactly one update, on the third edge after first sampled high. Two presses separated by 1 low cycle → two updates.
- Load with LoadValue=7 coincident with a pulse (Mode=01) → Count=7 with no increment. LoadValue=15 → Count=9. Clear together with Load → Count=0.
- WIDTH=8, MODULUS=200, STEP=50, from Count=180 with Mode=10 → 30, Wrap=1. Async Reset asserted mid-cycle → Count=0 before the next edge.
